uart_hd_responder: RTL and testbench
====================================

// Module: uart_hd_responder
// PURPOSE
//  Responder end of the half-duplex serial port. Owns one shared serial line: receives a
//  command byte (8N1, LSB first), hands it to the host, then turns the line around and
//  transmits the host's response byte. The line is released to the initiator afterwards.
//  Sits between the pad (tristate buffer driven by o_Line/o_Line_OE) and host logic.
// PARAMETERS
//  CLKS_PER_BIT      87  clocks per bit period (>=4)
//  TURNAROUND_BITS   2   idle bit periods, OE low, between accepted response and TX start bit
//  RSP_TIMEOUT_BITS  64  bit periods to wait for i_Rsp_DV before abandoning the transaction
// PORTS
//  i_Clock      in   1  clock, all logic on rising edge
//  i_Rst_n      in   1  asynchronous active-low reset
//  i_Line       in   1  serial line as seen at the pad (asynchronous)
//  o_Line       out  1  value driven onto line when o_Line_OE=1
//  o_Line_OE    out  1  1 = responder drives the line
//  o_Cmd_DV     out  1  one-cycle pulse: o_Cmd_Byte valid
//  o_Cmd_Byte   out  8  last received command byte (held until next command)
//  i_Rsp_DV     in   1  one-cycle strobe: i_Rsp_Byte valid
//  i_Rsp_Byte   in   8  response byte
//  o_Busy       out  1  1 in every state except IDLE
//  o_Frame_Err  out  1  one-cycle pulse: stop bit sampled low
//  o_Timeout    out  1  one-cycle pulse: no response within RSP_TIMEOUT_BITS
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, o_Line=1, o_Line_OE=0, o_Cmd_DV=0, o_Cmd_Byte=0,
//   o_Busy=0, o_Frame_Err=0, o_Timeout=0, synchroniser flops=1, counters=0, armed=0.
//  i_Line passes a 2-flop synchroniser (reset 1); all RX decisions use the synchronised value.
//  armed: set when synchronised line is 1 in IDLE; cleared on leaving IDLE. Start detect
//   only while armed (a held-low line after a framing error does not retrigger).
//  States / transitions:
//   IDLE: armed & line=0 -> RX_START, clk_cnt=0.
//   RX_START: at clk_cnt=(CLKS_PER_BIT-1)/2: line=0 -> RX_DATA, else IDLE (glitch reject).
//   RX_DATA: sample every CLKS_PER_BIT clocks from mid-start; bit i -> byte[i]; after bit 7
//    -> RX_STOP.
//   RX_STOP: sample at next midpoint. 1 -> o_Cmd_Byte<=byte, o_Cmd_DV=1 next cycle,
//    -> WAIT_RSP. 0 -> o_Frame_Err=1 next cycle, o_Cmd_Byte unchanged, -> IDLE.
//   WAIT_RSP: i_Rsp_DV -> latch i_Rsp_Byte, -> TURN. No strobe within
//    RSP_TIMEOUT_BITS*CLKS_PER_BIT clocks -> o_Timeout pulse, -> IDLE.
//    i_Rsp_DV in the same cycle as o_Cmd_DV is accepted (zero-latency host).
//   TURN: OE=0 for TURNAROUND_BITS*CLKS_PER_BIT clocks -> TX_START.
//   TX_START: OE=1, o_Line=0 for CLKS_PER_BIT clocks -> TX_DATA.
//   TX_DATA: o_Line=rsp[i], i=0..7, CLKS_PER_BIT clocks each -> TX_STOP.
//   TX_STOP: o_Line=1 for CLKS_PER_BIT clocks; then OE=0 -> IDLE.
//  i_Rsp_DV outside WAIT_RSP is ignored (no queueing). i_Line ignored while OE=1.
//  o_Line=1 whenever OE=0. o_Line/o_Line_OE are registered (glitch-free at the pad).
//  Latency: o_Cmd_DV 1 clk after stop-bit midpoint sample; start bit edge exactly
//   TURNAROUND_BITS*CLKS_PER_BIT+1 clks after the i_Rsp_DV cycle.
//  Counters sized $clog2(max count+1); clk_cnt wraps to 0 at each bit boundary.
// TESTING (CLKS_PER_BIT=87, 100 ns clock, bit=8.7 us)
//  1 Drive 8'h3F 8N1 on i_Line -> one o_Cmd_DV pulse, o_Cmd_Byte=8'h3F, o_Frame_Err=0.
//  2 Then i_Rsp_DV with 8'hA5 -> OE low 174 clks, then line 0,1,0,1,0,0,1,0,1, 87 clks each,
//    then OE=0, o_Busy=0; decoded byte 8'hA5.
//  3 Send 8'h55 with stop bit forced 0 -> o_Frame_Err pulse, no o_Cmd_DV, o_Cmd_Byte unchanged;
//    hold line low 20 bits -> no new start until line returns 1.
//  4 30-clock low glitch on idle line -> stays/returns IDLE, no pulses, OE=0.
//  5 Valid command, no i_Rsp_DV -> o_Timeout pulse 64*87 clks after WAIT_RSP entry, OE never 1.
//  6 Assert i_Rst_n=0 mid TX_DATA -> OE=0, o_Line=1 immediately; next command (8'h3F) works.

Source files
------------

// File: rtl/uart_hd_responder.sv
// Half-duplex UART responder: receives an 8N1 command byte, hands it to the host,
// turns the shared line around and transmits the host's response byte.
module uart_hd_responder #(
  parameter int unsigned CLKS_PER_BIT     = 87,
  parameter int unsigned TURNAROUND_BITS  = 2,
  parameter int unsigned RSP_TIMEOUT_BITS = 64
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Line,
  output logic       o_Line,
  output logic       o_Line_OE,
  output logic       o_Cmd_DV,
  output logic [7:0] o_Cmd_Byte,
  input  logic       i_Rsp_DV,
  input  logic [7:0] i_Rsp_Byte,
  output logic       o_Busy,
  output logic       o_Frame_Err,
  output logic       o_Timeout
);

  localparam int unsigned MID_CNT   = (CLKS_PER_BIT - 1) / 2;
  localparam int unsigned TURN_CLKS = TURNAROUND_BITS * CLKS_PER_BIT;
  localparam int unsigned TO_CLKS   = RSP_TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned WAIT_MAX  = (TURN_CLKS > TO_CLKS) ? TURN_CLKS : TO_CLKS;
  localparam int unsigned CW        = $clog2(CLKS_PER_BIT);
  localparam int unsigned WW        = $clog2(WAIT_MAX);

  typedef enum logic [3:0] {
    IDLE, RX_START, RX_DATA, RX_STOP, WAIT_RSP, TURN, TX_START, TX_DATA, TX_STOP
  } state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync2_q;
  logic          armed_q, armed_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic [7:0]    rsp_q, rsp_d;
  logic [7:0]    cmd_byte_q, cmd_byte_d;
  logic          cmd_dv_q, cmd_dv_d;
  logic          ferr_q, ferr_d;
  logic          tout_q, tout_d;
  logic          line_q, line_d;
  logic          oe_q, oe_d;
  logic          rx;
  logic          bit_end;

  assign rx      = sync2_q;
  assign bit_end = (clk_cnt_q == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d    = state_q;
    armed_d    = armed_q;
    clk_cnt_d  = clk_cnt_q + CW'(1);
    wait_cnt_d = wait_cnt_q;
    bit_d      = bit_q;
    rx_byte_d  = rx_byte_q;
    rsp_d      = rsp_q;
    cmd_byte_d = cmd_byte_q;
    cmd_dv_d   = 1'b0;
    ferr_d     = 1'b0;
    tout_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        if (rx) armed_d = 1'b1;
        // Armed only after seeing an idle-high line, so a stuck-low line cannot retrigger
        if (armed_q && !rx) begin
          state_d = RX_START;
          armed_d = 1'b0;
        end
      end
      RX_START: begin
        if (clk_cnt_q == CW'(MID_CNT)) begin
          clk_cnt_d = '0;
          bit_d     = '0;
          state_d   = rx ? IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (bit_end) begin
          clk_cnt_d        = '0;
          rx_byte_d[bit_q] = rx;
          bit_d            = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          if (rx) begin
            cmd_byte_d = rx_byte_q;
            cmd_dv_d   = 1'b1;
            wait_cnt_d = '0;
            state_d    = WAIT_RSP;
          end else begin
            ferr_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      WAIT_RSP: begin
        clk_cnt_d  = '0;
        wait_cnt_d = wait_cnt_q + WW'(1);
        if (i_Rsp_DV) begin
          rsp_d      = i_Rsp_Byte;
          wait_cnt_d = '0;
          state_d    = TURN;
        end else if (wait_cnt_q == WW'(TO_CLKS - 1)) begin
          tout_d  = 1'b1;
          state_d = IDLE;
        end
      end
      TURN: begin
        clk_cnt_d  = '0;
        wait_cnt_d = wait_cnt_q + WW'(1);
        if (wait_cnt_q == WW'(TURN_CLKS - 1)) state_d = TX_START;
      end
      TX_START: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          bit_d     = '0;
          state_d   = TX_DATA;
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          bit_d     = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = TX_STOP;
        end
      end
      TX_STOP: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Pad drivers follow the next state so they change on the same edge as the state
    oe_d   = 1'b0;
    line_d = 1'b1;
    unique case (state_d)
      TX_START: begin oe_d = 1'b1; line_d = 1'b0;         end
      TX_DATA:  begin oe_d = 1'b1; line_d = rsp_d[bit_d]; end
      TX_STOP:  begin oe_d = 1'b1; line_d = 1'b1;         end
      default:  ;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q    <= IDLE;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      armed_q    <= 1'b0;
      clk_cnt_q  <= '0;
      wait_cnt_q <= '0;
      bit_q      <= '0;
      rx_byte_q  <= '0;
      rsp_q      <= '0;
      cmd_byte_q <= '0;
      cmd_dv_q   <= 1'b0;
      ferr_q     <= 1'b0;
      tout_q     <= 1'b0;
      line_q     <= 1'b1;
      oe_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= i_Line;
      sync2_q    <= sync1_q;
      armed_q    <= armed_d;
      clk_cnt_q  <= clk_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      bit_q      <= bit_d;
      rx_byte_q  <= rx_byte_d;
      rsp_q      <= rsp_d;
      cmd_byte_q <= cmd_byte_d;
      cmd_dv_q   <= cmd_dv_d;
      ferr_q     <= ferr_d;
      tout_q     <= tout_d;
      line_q     <= line_d;
      oe_q       <= oe_d;
    end
  end

  assign o_Line      = line_q;
  assign o_Line_OE   = oe_q;
  assign o_Cmd_DV    = cmd_dv_q;
  assign o_Cmd_Byte  = cmd_byte_q;
  assign o_Busy      = (state_q != IDLE);
  assign o_Frame_Err = ferr_q;
  assign o_Timeout   = tout_q;

endmodule

// File: tb/tb_uart_hd_responder.sv
// Scoreboard bench for uart_hd_responder: stimulus queues expected events, a
// negedge monitor pops and compares them as the DUT produces them.
module tb_uart_hd_responder;

  localparam int CPB = 87;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       host_line = 1'b1;
  logic       rsp_dv = 1'b0;
  logic [7:0] rsp_byte = '0;
  logic       i_line;
  logic       o_line, o_oe, o_cmd_dv, o_busy, o_ferr, o_tout;
  logic [7:0] o_cmd_byte;

  assign i_line = o_oe ? o_line : host_line;

  always #50 clk = ~clk;

  uart_hd_responder #(
    .CLKS_PER_BIT    (CPB),
    .TURNAROUND_BITS (2),
    .RSP_TIMEOUT_BITS(64)
  ) dut (
    .i_Clock    (clk),
    .i_Rst_n    (rst_n),
    .i_Line     (i_line),
    .o_Line     (o_line),
    .o_Line_OE  (o_oe),
    .o_Cmd_DV   (o_cmd_dv),
    .o_Cmd_Byte (o_cmd_byte),
    .i_Rsp_DV   (rsp_dv),
    .i_Rsp_Byte (rsp_byte),
    .o_Busy     (o_busy),
    .o_Frame_Err(o_ferr),
    .o_Timeout  (o_tout)
  );

  typedef enum int {EV_CMD, EV_FERR, EV_TOUT, EV_TX} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  ev_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  bit  done = 1'b0;
  bit  expect_idle = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Monitor state
  bit         rst_prev = 1'b1;
  bit         oe_prev = 1'b0;
  bit         idle_prev = 1'b0;
  bit         idle_busy = 1'b0;
  bit         tx_act = 1'b0;
  int         tx_off = 0;
  logic [7:0] tx_byte = '0;
  logic [7:0] tx_exp = '0;
  int         last_cmd_cyc = 0;
  bit         finished = 1'b0;

  function automatic bit pop_expect(input ev_kind_t kind, output ev_t e);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d, required no event (cycle %0d)", int'(kind), cyc);
      return 1'b0;
    end
    e = exp_q.pop_front();
    chk("event_kind", int'(kind), int'(e.kind));
    return (kind == e.kind);
  endfunction

  always @(negedge clk) begin
    ev_t e;
    if (!rst_n) begin
      if (rst_prev) begin
        chk("rst_oe", o_oe, 0);
        chk("rst_line", o_line, 1);
        chk("rst_busy", o_busy, 0);
        chk("rst_cmd_dv", o_cmd_dv, 0);
        chk("rst_cmd_byte", o_cmd_byte, 0);
        chk("rst_ferr", o_ferr, 0);
        chk("rst_tout", o_tout, 0);
      end
      tx_act = 1'b0;
    end else begin
      if (o_cmd_dv && pop_expect(EV_CMD, e)) begin
        chk("cmd_byte", o_cmd_byte, e.data);
        chk("cmd_no_ferr", o_ferr, 0);
        last_cmd_cyc = cyc;
      end
      if (o_ferr && pop_expect(EV_FERR, e))
        chk("ferr_cmd_byte_held", o_cmd_byte, e.data);
      if (o_tout && pop_expect(EV_TOUT, e))
        chk("timeout_delay", cyc - last_cmd_cyc, 64 * CPB);
      if (tx_act) begin
        tx_off++;
        if (tx_off % CPB == 43) begin
          if (tx_off / CPB >= 1 && tx_off / CPB <= 8) begin
            tx_byte[tx_off / CPB - 1] = o_line;
            chk("tx_oe_held", o_oe, 1);
          end else if (tx_off / CPB == 9) begin
            chk("tx_stop_bit", o_line, 1);
          end
        end
        if (tx_off == 10 * CPB) begin
          chk("tx_oe_released", o_oe, 0);
          chk("tx_busy_cleared", o_busy, 0);
          chk("tx_line_idle", o_line, 1);
          chk("tx_byte", tx_byte, tx_exp);
          tx_act = 1'b0;
        end
      end
      if (o_oe && !oe_prev && pop_expect(EV_TX, e)) begin
        chk("tx_start_level", o_line, 0);
        chk("tx_start_cycle", cyc, e.cyc);
        tx_act  = 1'b1;
        tx_off  = 0;
        tx_byte = '0;
        tx_exp  = e.data;
      end
      if (expect_idle) idle_busy = idle_busy | o_busy;
      if (idle_prev && !expect_idle) begin
        chk("idle_window_busy", idle_busy, 0);
        idle_busy = 1'b0;
      end
    end
    idle_prev = expect_idle;
    rst_prev  = rst_n;
    oe_prev   = o_oe;
    if (done && !finished) begin
      finished = 1'b1;
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    host_line = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      host_line = b[i];
      idle(CPB);
    end
    host_line = stop;
    idle(CPB);
    host_line = 1'b1;
  endtask

  // Waits for the command strobe, then answers after 0 or 3 cycles
  task automatic respond(input logic [7:0] b, input bit zero_lat);
    int n = 0;
    while (n < 3000) begin
      @(negedge clk);
      n++;
      if (o_cmd_dv) break;
    end
    if (!o_cmd_dv) return;
    if (!zero_lat) idle(3);
    rsp_byte = b;
    rsp_dv   = 1'b1;
    exp_q.push_back('{kind: EV_TX, data: b, cyc: cyc + 2 * CPB + 1});
    idle(1);
    rsp_dv = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(2 * CPB);

    // Command 3F, response A5 three cycles later
    exp_q.push_back('{kind: EV_CMD, data: 8'h3F, cyc: 0});
    fork
      send_byte(8'h3F, 1'b1);
      respond(8'hA5, 1'b0);
    join
    idle(1200);

    // Framing error, then line held low for 20 bits
    exp_q.push_back('{kind: EV_FERR, data: 8'h3F, cyc: 0});
    send_byte(8'h55, 1'b0);
    host_line   = 1'b0;
    expect_idle = 1'b1;
    idle(20 * CPB);
    expect_idle = 1'b0;
    host_line   = 1'b1;
    idle(3 * CPB);

    // 30-clock glitch on idle line
    host_line = 1'b0;
    idle(30);
    host_line = 1'b1;
    idle(100);
    expect_idle = 1'b1;
    idle(CPB);
    expect_idle = 1'b0;
    idle(CPB);

    // Command with no response -> timeout
    exp_q.push_back('{kind: EV_CMD, data: 8'h12, cyc: 0});
    exp_q.push_back('{kind: EV_TOUT, data: 8'h00, cyc: 0});
    send_byte(8'h12, 1'b1);
    for (int i = 0; i < 7000 && !o_tout; i++) @(negedge clk);
    idle(2 * CPB);

    // Reset in the middle of TX_DATA
    exp_q.push_back('{kind: EV_CMD, data: 8'h81, cyc: 0});
    fork
      send_byte(8'h81, 1'b1);
      respond(8'h5A, 1'b0);
    join
    for (int i = 0; i < 500 && !o_oe; i++) @(negedge clk);
    idle(300);
    @(posedge clk);
    #10 rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(2 * CPB);

    // Command after reset with a zero-latency response
    exp_q.push_back('{kind: EV_CMD, data: 8'h3F, cyc: 0});
    fork
      send_byte(8'h3F, 1'b1);
      respond(8'hC3, 1'b1);
    join
    idle(1200);

    done = 1'b1;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
